// File: rtl/arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner identities
// and the round-robin tie-break rule.
package arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_A = 2'd1;
    localparam logic [1:0] BUSY_B = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StBusyA = BUSY_A,
        StBusyB = BUSY_B,
        StDone  = DONE
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // A wins when it is the sole requester, or on a tie when B owned the port last.
    function automatic logic pick_a(input logic a_req, input logic b_req, input logic last);
        return a_req && (!b_req || (last == OWN_B));
    endfunction

endpackage

// File: rtl/mux2.sv
// 16-bit two-input multiplexer: sel=0 passes a, sel=1 passes b.
module mux2 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and handshake sequencer for the shared 16-bit memory port,
// with one-cycle done pulses and a stall timeout that aborts the transaction.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    input  logic        a_we,
    output logic        a_gnt,
    output logic        a_done,

    input  logic        b_req,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    input  logic        b_we,
    output logic        b_gnt,
    output logic        b_done,

    output logic        m_valid,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_we,
    input  logic        m_ready,
    input  logic [15:0] m_rdata,

    output logic [15:0] rdata,
    output logic        err
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state;
    logic             last;
    logic             sel;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    mux2 u_addr_mux (
        .a   (a_addr),
        .b   (b_addr),
        .sel (sel),
        .y   (m_addr)
    );

    mux2 u_wdata_mux (
        .a   (a_wdata),
        .b   (b_wdata),
        .sel (sel),
        .y   (m_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            last    <= OWN_B;
            sel     <= OWN_A;
            cnt     <= '0;
            a_gnt   <= 1'b0;
            b_gnt   <= 1'b0;
            a_done  <= 1'b0;
            b_done  <= 1'b0;
            m_valid <= 1'b0;
            m_we    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (a_req || b_req) begin
                        cnt     <= '0;
                        m_valid <= 1'b1;
                        if (pick_a(a_req, b_req, last)) begin
                            state <= StBusyA;
                            a_gnt <= 1'b1;
                            sel   <= OWN_A;
                            m_we  <= a_we;
                        end else begin
                            state <= StBusyB;
                            b_gnt <= 1'b1;
                            sel   <= OWN_B;
                            m_we  <= b_we;
                        end
                    end
                end
                StBusyA, StBusyB: begin
                    // m_ready takes priority over a coincident timeout.
                    if (m_ready || timeout_hit) begin
                        state   <= StDone;
                        a_gnt   <= 1'b0;
                        b_gnt   <= 1'b0;
                        m_valid <= 1'b0;
                        m_we    <= 1'b0;
                        last    <= (state == StBusyB) ? OWN_B : OWN_A;
                        a_done  <= (state == StBusyA);
                        b_done  <= (state == StBusyB);
                        err     <= !m_ready;
                        rdata   <= m_ready ? m_rdata : 16'h0000;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    state  <= StIdle;
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    err    <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_done, b_gnt, b_done;
    logic        m_valid, m_we, m_ready, err;
    logic [15:0] m_addr, m_wdata, m_rdata, rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT (15),
        .CNT_W   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req   (a_req),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_we    (a_we),
        .a_gnt   (a_gnt),
        .a_done  (a_done),
        .b_req   (b_req),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_we    (b_we),
        .b_gnt   (b_gnt),
        .b_done  (b_done),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_we    (m_we),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .rdata   (rdata),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        a_req   = 1'b0;
        b_req   = 1'b0;
        a_we    = 1'b0;
        b_we    = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        b_addr  = '0;
        b_wdata = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_b_order;
    int         cycles;

    initial begin
        apply_reset();
        check("rst_a_gnt",   a_gnt,   0);
        check("rst_b_gnt",   b_gnt,   0);
        check("rst_a_done",  a_done,  0);
        check("rst_b_done",  b_done,  0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_we",    m_we,    0);
        check("rst_err",     err,     0);
        check("rst_rdata",   rdata,   0);

        // Single A read, memory ready in the second BUSY cycle.
        a_req  = 1'b1;
        a_addr = 16'h1234;
        a_we   = 1'b0;
        tick();
        check("a_gnt",     a_gnt,   1);
        check("a_m_valid", m_valid, 1);
        check("a_m_addr",  m_addr,  16'h1234);
        check("a_m_we",    m_we,    0);
        tick();
        check("a_gnt_hold", a_gnt, 1);
        m_ready = 1'b1;
        m_rdata = 16'hABCD;
        tick();
        check("a_done",     a_done,  1);
        check("a_rdata",    rdata,   16'hABCD);
        check("a_err",      err,     0);
        check("a_done_gnt", a_gnt,   0);
        check("a_done_mv",  m_valid, 0);
        a_req   = 1'b0;
        m_ready = 1'b0;
        tick();
        check("a_done_pulse", a_done, 0);

        // Single B write.
        b_req   = 1'b1;
        b_addr  = 16'h5678;
        b_wdata = 16'hEF01;
        b_we    = 1'b1;
        tick();
        check("b_gnt",     b_gnt,   1);
        check("b_m_we",    m_we,    1);
        check("b_m_wdata", m_wdata, 16'hEF01);
        check("b_m_addr",  m_addr,  16'h5678);
        m_ready = 1'b1;
        tick();
        check("b_done", b_done, 1);
        check("b_err",  err,    0);
        check("b_m_we_off", m_we, 0);
        b_req   = 1'b0;
        b_we    = 1'b0;
        m_ready = 1'b0;
        tick();

        // Contention from reset: expected owners A, B, A, B (bit set = B).
        apply_reset();
        exp_b_order = 4'b1010;
        a_req   = 1'b1;
        b_req   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr%0d_a_gnt", i), a_gnt, !exp_b_order[i]);
            check($sformatf("rr%0d_b_gnt", i), b_gnt, exp_b_order[i]);
            tick();
            check($sformatf("rr%0d_a_done", i), a_done, !exp_b_order[i]);
            check($sformatf("rr%0d_b_done", i), b_done, exp_b_order[i]);
            tick();
            check($sformatf("rr%0d_idle", i), a_gnt | b_gnt | m_valid, 0);
        end
        a_req   = 1'b0;
        b_req   = 1'b0;
        m_ready = 1'b0;
        tick();

        // Timeout abort on A: done 16 cycles after the grant appears.
        m_rdata = 16'h7777;
        a_req   = 1'b1;
        tick();
        check("to_a_gnt", a_gnt, 1);
        cycles = 1;
        while (!a_done && cycles < 40) begin
            tick();
            cycles++;
        end
        check("to_cycles", cycles,  16);
        check("to_err",    err,     1);
        check("to_rdata",  rdata,   0);
        a_req = 1'b0;
        tick();
        check("to_err_clr", err, 0);

        // m_ready arriving on the timeout cycle wins.
        b_req = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("co_b_gnt", b_gnt, 1);
        m_ready = 1'b1;
        m_rdata = 16'h4242;
        tick();
        check("co_b_done", b_done, 1);
        check("co_err",    err,    0);
        check("co_rdata",  rdata,  16'h4242);
        b_req   = 1'b0;
        m_ready = 1'b0;
        tick();

        // Asynchronous reset in the middle of BUSY_B.
        b_req = 1'b1;
        tick();
        check("ar_b_gnt", b_gnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_b_gnt_drop", b_gnt,   0);
        check("ar_m_valid",    m_valid, 0);
        check("ar_b_done",     b_done,  0);
        @(negedge clk);
        check("ar_b_done_hold", b_done, 0);
        rst_n = 1'b1;
        a_req = 1'b1;
        tick();
        check("ar_tie_a", a_gnt, 1);
        check("ar_tie_b", b_gnt, 0);
        a_req = 1'b0;
        b_req = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
